// File: rtl/logic_eval_pkg.sv
// Shared types and the evaluator function for logic_eval_arbiter.
// State encoding, operand field positions, and o = ~((a&b)|(c^d)).
package logic_eval_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int OP_A = 3;
    localparam int OP_B = 2;
    localparam int OP_C = 1;
    localparam int OP_D = 0;

    function automatic logic lea_eval(input logic [3:0] op);
        return ~((op[OP_A] & op[OP_B]) | (op[OP_C] ^ op[OP_D]));
    endfunction

endpackage

// File: rtl/logic_eval_arbiter_rr_pick.sv
// Round-robin picker: first set req at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies gnt with its own enable.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the lane closest to ptr wins last.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (int'(ptr) + k >= NREQ)
                idx = IDW'(int'(ptr) + k - NREQ);
            else
                idx = IDW'(int'(ptr) + k);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/logic_eval_arbiter.sv
// Shares one registered ~((a&b)|(c^d)) evaluator among NREQ lanes, round-robin.
// Latency: 1 cycle from accept to rsp_*; 1 result/cycle while rsp_ready is high.
// Backpressure: rsp_ready=0 with a held result freezes rsp_* and drops req_ready. Option: LEA_STATS_EN.
module logic_eval_arbiter
    import logic_eval_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [4*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_o,
    input  logic                   rsp_ready
`ifdef LEA_STATS_EN
    ,output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

    state_t         state, state_nx;
    logic [IDW-1:0] ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           any;
    logic           ge;
    logic           grant;
    logic [3:0]     op;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign ge        = (state == ST_IDLE) | rsp_ready;
    assign grant     = ge & any;
    assign req_ready = ge ? gnt : '0;
    assign rsp_valid = (state == ST_RESP);
    assign op        = req_data[{gnt_id, 2'b00} +: 4];

    always_comb begin
        state_nx = state;
        if (ge)
            state_nx = any ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            rsp_id <= '0;
            rsp_o  <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                rsp_o  <= lea_eval(op);
                rsp_id <= gnt_id;
                ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

`ifdef LEA_STATS_EN
    logic [STAT_W-1:0] cnt [NREQ];

    // Saturating per-lane grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (grant && gnt[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++)
            stat_cnt[i*STAT_W +: STAT_W] = cnt[i];
    end
`else
    logic unused_stat_w;
    assign unused_stat_w = ^STAT_W;
`endif

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Directed bench for logic_eval_arbiter; hand-computed expectations.
// Stats checks apply when LEA_STATS_EN is defined (STAT_W=2).
module tb_logic_eval_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_o;
    logic        rsp_ready;
`ifdef LEA_STATS_EN
    logic [7:0]  stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] eval_mask;
    logic [3:0]  rr_data [4];

    logic_eval_arbiter #(.NREQ(4), .IDW(2), .STAT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_o     (rsp_o),
        .rsp_ready (rsp_ready)
`ifdef LEA_STATS_EN
        ,.stat_cnt (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Expected evaluator outputs for operands 0..15 (1 at 0,3,4,7,8,11).
        eval_mask = 16'h0999;
        rr_data[0] = 4'b0000;
        rr_data[1] = 4'b0001;
        rr_data[2] = 4'b0011;
        rr_data[3] = 4'b1111;

        do_reset();
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_id", {30'd0, rsp_id}, 32'd0);
        check("rst_o", {31'd0, rsp_o}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);

        // Single lane 2, operand 1100.
        req_valid = 4'b0100;
        req_data  = 16'h0C00;
        #1;
        check("t1_req_ready", {28'd0, req_ready}, 32'h4);
        step();
        check("t1_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_id", {30'd0, rsp_id}, 32'd2);
        check("t1_o", {31'd0, rsp_o}, 32'd0);
        req_valid = '0;
        step();
        check("t1_idle", {31'd0, rsp_valid}, 32'd0);

        // Lane 0 sweeps every operand back-to-back.
        for (int v = 0; v < 16; v++) begin
            req_valid = 4'b0001;
            req_data  = {12'd0, 4'(v)};
            step();
            check($sformatf("t2_o_%0d", v), {31'd0, rsp_o}, {31'd0, eval_mask[v]});
            check($sformatf("t2_id_%0d", v), {30'd0, rsp_id}, 32'd0);
        end
        req_valid = '0;
        step();

        // Round-robin from a freshly reset pointer.
        do_reset();
        req_valid = 4'b1111;
        req_data  = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t3_id_%0d", i), {30'd0, rsp_id}, 32'(i % 4));
            check($sformatf("t3_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("t3_o_%0d", i), {31'd0, rsp_o}, {31'd0, ~(i[0])});
        end

        // Backpressure: lane 3 result (o=0) held, lanes 1,3 waiting with o=1 operands.
        req_valid = 4'b1010;
        req_data  = 16'h0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_ready_%0d", i), {28'd0, req_ready}, 32'd0);
            step();
            check($sformatf("t4_id_%0d", i), {30'd0, rsp_id}, 32'd3);
            check($sformatf("t4_o_%0d", i), {31'd0, rsp_o}, 32'd0);
            check($sformatf("t4_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_rel_ready", {28'd0, req_ready}, 32'h2);
        step();
        check("t4_rel_id1", {30'd0, rsp_id}, 32'd1);
        check("t4_rel_o1", {31'd0, rsp_o}, 32'd1);
        check("t4_next_ready", {28'd0, req_ready}, 32'h8);
        step();
        check("t4_rel_id3", {30'd0, rsp_id}, 32'd3);

        // Park the pointer at 2 with a result held, then reset.
        req_valid = 4'b0010;
        step();
        check("t5_pre_id", {30'd0, rsp_id}, 32'd1);
        rsp_ready = 1'b0;
        rst       = 1'b1;
        req_valid = 4'b0110;
        step();
        check("t5_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_id", {30'd0, rsp_id}, 32'd0);
        rst = 1'b0;
        #1;
        check("t5_ready", {28'd0, req_ready}, 32'h2);
        step();
        check("t5_first_id", {30'd0, rsp_id}, 32'd1);
        rsp_ready = 1'b1;
        req_valid = '0;
        step();

`ifdef LEA_STATS_EN
        do_reset();
        check("t6_clr", {24'd0, stat_cnt}, 32'd0);
        req_valid = 4'b0001;
        step();
        step();
        check("t6_cnt2", {24'd0, stat_cnt}, 32'h02);
        step();
        step();
        step();
        check("t6_sat", {24'd0, stat_cnt}, 32'h03);
        req_valid = '0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
